cache_ctrl_fsm: RTL and testbench

CACHE_CTRL_FSM -- requirements
Module: cache_ctrl_fsm

---
 rtl/cache_ctrl_fsm.sv | 170 +++++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped, write-back, write-allocate cache controller: 1024 lines of
// 128 bits, an 18-bit tag per line, and a four-state miss-handling FSM.

package cache_def;
    localparam int TAG_W     = 18;
    localparam int INDEX_W   = 10;
    localparam int WORDS     = 4;
    localparam int NUM_LINES = 1 << INDEX_W;

    typedef logic [TAG_W-1:0]         tag_t;
    typedef logic [INDEX_W-1:0]       index_t;
    typedef logic [1:0]               word_sel_t;
    typedef logic [WORDS-1:0][31:0]   line_t;

    // Byte offset [1:0] is dropped when the request is latched.
    typedef struct packed {
        tag_t      tag;
        index_t    index;
        word_sel_t word;
    } req_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE_TAG,
        ALLOCATE,
        WRITE_BACK
    } state_t;
endpackage

module cache_ctrl_fsm
    import cache_def::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  cpu_req_addr,
    input  logic [31:0]  cpu_req_data,
    input  logic         cpu_req_rw,
    input  logic         cpu_req_valid,
    output logic [31:0]  cpu_res_data,
    output logic         cpu_res_ready,
    output logic [31:0]  mem_req_addr,
    output logic [127:0] mem_req_data,
    output logic         mem_req_rw,
    output logic         mem_req_valid,
    input  logic [127:0] mem_data,
    input  logic         mem_ready
);

    state_t    state_q, state_d;
    req_addr_t req_addr_q;
    logic [31:0] req_data_q;
    logic      req_rw_q;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    tag_t  tag_mem  [NUM_LINES];
    line_t data_mem [NUM_LINES];

    tag_t  cur_tag;
    line_t cur_line;
    logic  cur_valid;
    logic  cur_dirty;
    logic  hit;
    logic  fill_done;
    logic  write_hit;

    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_req_addr[1:0];

    assign cur_tag   = tag_mem[req_addr_q.index];
    assign cur_line  = data_mem[req_addr_q.index];
    assign cur_valid = valid_q[req_addr_q.index];
    assign cur_dirty = dirty_q[req_addr_q.index];
    assign hit       = cur_valid && (cur_tag == req_addr_q.tag);
    assign fill_done = (state_q == ALLOCATE) && mem_ready;
    assign write_hit = (state_q == COMPARE_TAG) && hit && req_rw_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d; otherwise a latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_valid) state_d = COMPARE_TAG;
            end
            COMPARE_TAG: begin
                if (hit)                         state_d = IDLE;
                else if (cur_valid && cur_dirty) state_d = WRITE_BACK;
                else                             state_d = ALLOCATE;
            end
            WRITE_BACK: begin
                if (mem_ready) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                if (mem_ready) state_d = COMPARE_TAG;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_res_ready = 1'b0;
        cpu_res_data  = cur_line[req_addr_q.word];
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 32'h0;
        mem_req_data  = cur_line;
        unique case (state_q)
            COMPARE_TAG: begin
                cpu_res_ready = hit;
            end
            WRITE_BACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {cur_tag, req_addr_q.index, 4'b0000};
            end
            ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_addr_q.tag, req_addr_q.index, 4'b0000};
            end
            default: ;
        endcase
    end

    // The request is only sampled in IDLE; later cpu_req_valid activity is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_q <= '0;
            req_data_q <= '0;
            req_rw_q   <= 1'b0;
        end else if (state_q == IDLE && cpu_req_valid) begin
            req_addr_q <= req_addr_t'(cpu_req_addr[31:2]);
            req_data_q <= cpu_req_data;
            req_rw_q   <= cpu_req_rw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_done) begin
            valid_q[req_addr_q.index] <= 1'b1;
            dirty_q[req_addr_q.index] <= 1'b0;
        end else if (write_hit) begin
            dirty_q[req_addr_q.index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; the cleared valid bits make
    // their contents irrelevant and keep them mappable to RAM.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[req_addr_q.index]  <= req_addr_q.tag;
            data_mem[req_addr_q.index] <= line_t'(mem_data);
        end else if (write_hit) begin
            data_mem[req_addr_q.index][req_addr_q.word] <= req_data_q;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm: fill, write hit, dirty/clean conflicts,
// reset abort during ALLOCATE and a long write-back stall.

module tb_cache_ctrl_fsm;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  cpu_req_addr = '0;
    logic [31:0]  cpu_req_data = '0;
    logic         cpu_req_rw = 1'b0;
    logic         cpu_req_valid = 1'b0;
    logic [31:0]  cpu_res_data;
    logic         cpu_res_ready;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_req_rw;
    logic         mem_req_valid;
    logic [127:0] mem_data = '0;
    logic         mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FILL1 = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    localparam logic [127:0] WB1   = {32'hDDDD_DDDD, 32'h1234_5678, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    localparam logic [127:0] FILL2 = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
    localparam logic [127:0] FILL4 = {32'h8888_0003, 32'h8888_0002, 32'h8888_0001, 32'h8888_0000};
    localparam logic [127:0] WB4   = {32'h8888_0003, 32'h8888_0002, 32'hCAFE_F00D, 32'h8888_0000};
    localparam logic [127:0] FILL5 = {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h9999_0000};

    cache_ctrl_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_data  (cpu_req_data),
        .cpu_req_rw    (cpu_req_rw),
        .cpu_req_valid (cpu_req_valid),
        .cpu_res_data  (cpu_res_data),
        .cpu_res_ready (cpu_res_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_rw    (mem_req_rw),
        .mem_req_valid (mem_req_valid),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [31:0] addr, input logic [31:0] data, input logic rw);
        cpu_req_addr  = addr;
        cpu_req_data  = data;
        cpu_req_rw    = rw;
        cpu_req_valid = 1'b1;
        step();
    endtask

    task automatic finish_req();
        cpu_req_valid = 1'b0;
        step();
    endtask

    task automatic mem_reply(input int delay, input logic [127:0] d);
        repeat (delay) step();
        mem_data  = d;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
    endtask

    task automatic await_ready(input string tag, input logic [31:0] exp_data);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_res_ready) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check({tag, "_ready"}, 128'(seen), 128'(1));
        if (seen) check({tag, "_data"}, 128'(cpu_res_data), 128'(exp_data));
        finish_req();
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_ready", 128'(cpu_res_ready), 128'(0));
        check("rst_mvalid", 128'(mem_req_valid), 128'(0));
        check("rst_mrw", 128'(mem_req_rw), 128'(0));
        check("rst_maddr", 128'(mem_req_addr), 128'(0));
        step();
        rst_n = 1'b1;
        step();

        // Cold read miss with a 3-cycle fill
        start_req(32'h0000_1004, 32'h0, 1'b0);
        check("miss1_ready", 128'(cpu_res_ready), 128'(0));
        step();
        check("fill1_valid", 128'(mem_req_valid), 128'(1));
        check("fill1_rw", 128'(mem_req_rw), 128'(0));
        check("fill1_addr", 128'(mem_req_addr), 128'(32'h0000_1000));
        mem_reply(3, FILL1);
        check("fill1_drop", 128'(mem_req_valid), 128'(0));
        await_ready("rd1", 32'hBBBB_BBBB);

        // Write hit, then read it back
        start_req(32'h0000_1008, 32'h1234_5678, 1'b1);
        check("wr_hit_ready", 128'(cpu_res_ready), 128'(1));
        check("wr_hit_nomem", 128'(mem_req_valid), 128'(0));
        finish_req();
        start_req(32'h0000_1008, 32'h0, 1'b0);
        check("rd_after_wr_ready", 128'(cpu_res_ready), 128'(1));
        check("rd_after_wr_data", 128'(cpu_res_data), 128'(32'h1234_5678));
        finish_req();

        // mem_ready in IDLE does nothing
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("idle_memready_ignored", 128'(mem_req_valid), 128'(0));

        // Conflict with a dirty victim: write-back then fill
        start_req(32'h0000_5008, 32'h0, 1'b0);
        check("miss2_ready", 128'(cpu_res_ready), 128'(0));
        step();
        check("wb1_valid", 128'(mem_req_valid), 128'(1));
        check("wb1_rw", 128'(mem_req_rw), 128'(1));
        check("wb1_addr", 128'(mem_req_addr), 128'(32'h0000_1000));
        check("wb1_data", mem_req_data, WB1);
        mem_reply(2, 128'h0);
        check("fill2_valid", 128'(mem_req_valid), 128'(1));
        check("fill2_rw", 128'(mem_req_rw), 128'(0));
        check("fill2_addr", 128'(mem_req_addr), 128'(32'h0000_5000));
        mem_reply(1, FILL2);
        await_ready("rd2", 32'h4444_0002);

        // Conflict with a clean victim: fill only
        start_req(32'h0000_1008, 32'h0, 1'b0);
        step();
        check("fill3_valid", 128'(mem_req_valid), 128'(1));
        check("fill3_rw_no_wb", 128'(mem_req_rw), 128'(0));
        check("fill3_addr", 128'(mem_req_addr), 128'(32'h0000_1000));
        mem_reply(0, WB1);
        await_ready("rd3", 32'h1234_5678);

        // Reset two cycles into ALLOCATE
        start_req(32'h0000_2004, 32'h0, 1'b0);
        step();
        check("alloc_abort_pre", 128'(mem_req_valid), 128'(1));
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("abort_mvalid", 128'(mem_req_valid), 128'(0));
        check("abort_maddr", 128'(mem_req_addr), 128'(0));
        check("abort_ready", 128'(cpu_res_ready), 128'(0));
        cpu_req_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        start_req(32'h0000_2004, 32'h0, 1'b0);
        check("post_rst_miss", 128'(cpu_res_ready), 128'(0));
        step();
        check("post_rst_fill_valid", 128'(mem_req_valid), 128'(1));
        check("post_rst_fill_rw", 128'(mem_req_rw), 128'(0));
        check("post_rst_fill_addr", 128'(mem_req_addr), 128'(32'h0000_2000));
        mem_reply(0, FILL4);
        await_ready("rd4", 32'h8888_0001);

        // Dirty the line, then stall its write-back for 50 cycles
        start_req(32'h0000_2004, 32'hCAFE_F00D, 1'b1);
        check("wr2_hit_ready", 128'(cpu_res_ready), 128'(1));
        finish_req();
        start_req(32'h0000_6004, 32'h0, 1'b0);
        step();
        for (int i = 0; i < 50; i++) begin
            check("stall_valid", 128'(mem_req_valid), 128'(1));
            check("stall_rw", 128'(mem_req_rw), 128'(1));
            check("stall_addr", 128'(mem_req_addr), 128'(32'h0000_2000));
            check("stall_data", mem_req_data, WB4);
            check("stall_no_ready", 128'(cpu_res_ready), 128'(0));
            step();
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("wb_to_alloc_valid", 128'(mem_req_valid), 128'(1));
        check("wb_to_alloc_rw", 128'(mem_req_rw), 128'(0));
        check("wb_to_alloc_addr", 128'(mem_req_addr), 128'(32'h0000_6000));
        mem_reply(2, FILL5);
        await_ready("rd5", 32'h9999_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
